// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: sequencing controller for the stopwatch counter datapath.
// Turns the start/stop and lap/reset buttons into run, pause, lap and clear
// actions, generates the tick-rate count-enable pulse and drives the display
// hold and blank lines.
// Optional feature: define STOPWATCH_AUTOSLEEP_EN to add the SLEEP state, the
// inactivity counter and the psave_req power-saver input.
module stopwatch_ctrl #(
    parameter int TICK_DIV    = 100,
    parameter int IDLE_CYCLES = 3000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lr,
`ifdef STOPWATCH_AUTOSLEEP_EN
    input  logic       psave_req,
`endif
    output logic       cnt_en,
    output logic       cnt_clear,
    output logic       pause,
    output logic       disp_hold,
    output logic       disp_blank,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        LAP    = 3'd2,
        PAUSED = 3'd3,
        SLEEP  = 3'd4
    } state_e;

    localparam int           PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic          btn_ss_q, btn_lr_q;
    logic          ss_ev_q, lr_ev_q;
    logic          clear_d;
    logic          cnt_clear_q, pause_q, disp_hold_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          counting;

`ifdef STOPWATCH_AUTOSLEEP_EN
    localparam int            IW       = $clog2(IDLE_CYCLES);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES - 1);

    logic [IW-1:0] idle_q, idle_d;
    logic          ret_paused_q;
    logic          disp_blank_q;
    logic          idle_state;
    logic          sleep_req;
`endif

    // Button edge detect; events are registered so they last exactly one cycle.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_ss_q <= 1'b0;
            btn_lr_q <= 1'b0;
            ss_ev_q  <= 1'b0;
            lr_ev_q  <= 1'b0;
        end else begin
            btn_ss_q <= btn_ss;
            btn_lr_q <= btn_lr;
            ss_ev_q  <= btn_ss & ~btn_ss_q;
            lr_ev_q  <= btn_lr & ~btn_lr_q;
        end
    end

    assign counting = (state_q == RUN) || (state_q == LAP);
    assign cnt_en   = counting && (presc_q == PRESC_MAX);

`ifdef STOPWATCH_AUTOSLEEP_EN
    assign idle_state = (state_q == IDLE) || (state_q == PAUSED);
    assign sleep_req  = idle_state && (psave_req || (idle_q == IDLE_MAX));
`endif

    // Next-state decode; start/stop wins over lap/reset in the same cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ss_ev_q)      state_d = RUN;
                else if (lr_ev_q) clear_d = 1'b1;
`ifdef STOPWATCH_AUTOSLEEP_EN
                else if (sleep_req) state_d = SLEEP;
`endif
            end
            RUN: begin
                if (ss_ev_q)      state_d = PAUSED;
                else if (lr_ev_q) state_d = LAP;
            end
            LAP: begin
                if (ss_ev_q)      state_d = PAUSED;
                else if (lr_ev_q) state_d = RUN;
            end
            PAUSED: begin
                if (ss_ev_q) begin
                    state_d = RUN;
                end else if (lr_ev_q) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end
`ifdef STOPWATCH_AUTOSLEEP_EN
                else if (sleep_req) state_d = SLEEP;
`endif
            end
`ifdef STOPWATCH_AUTOSLEEP_EN
            SLEEP: begin
                // The waking event only restores the saved state.
                if (ss_ev_q || lr_ev_q) state_d = ret_paused_q ? PAUSED : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Prescaler next value: restart on IDLE->RUN, count in RUN/LAP, hold otherwise.
    always_comb begin
        presc_d = presc_q;
        if ((state_q == IDLE) && (state_d == RUN)) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
        end
    end

    // Prescaler register; holding in PAUSED keeps the tick phase across a pause.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) presc_q <= '0;
        else        presc_q <= presc_d;
    end

`ifdef STOPWATCH_AUTOSLEEP_EN
    // Inactivity counter next value: saturating count in IDLE/PAUSED only.
    always_comb begin
        idle_d = '0;
        if (!(ss_ev_q || lr_ev_q) && idle_state) begin
            idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1);
        end
    end

    // Inactivity counter and sleep return-state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q       <= '0;
            ret_paused_q <= 1'b0;
        end else begin
            idle_q <= idle_d;
            if ((state_d == SLEEP) && (state_q != SLEEP)) begin
                ret_paused_q <= (state_q == PAUSED);
            end
        end
    end
`endif

    // FSM state plus registered Moore outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_clear_q  <= 1'b0;
            pause_q      <= 1'b1;
            disp_hold_q  <= 1'b0;
`ifdef STOPWATCH_AUTOSLEEP_EN
            disp_blank_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_clear_q  <= clear_d;
            pause_q      <= !((state_d == RUN) || (state_d == LAP));
            disp_hold_q  <= (state_d == LAP);
`ifdef STOPWATCH_AUTOSLEEP_EN
            disp_blank_q <= (state_d == SLEEP);
`endif
        end
    end

    assign cnt_clear = cnt_clear_q;
    assign pause     = pause_q;
    assign disp_hold = disp_hold_q;
    assign state     = state_q;
`ifdef STOPWATCH_AUTOSLEEP_EN
    assign disp_blank = disp_blank_q;
`else
    assign disp_blank = 1'b0;
`endif

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the stopwatch counter datapath (counter chain, pause input, power-saver flag).
- Turns two push-button inputs into start/stop, lap and clear actions.
- Generates the tick-rate count-enable pulses and drives the datapath pause and clear lines.
- Manages display hold (lap) and display blanking (sleep).

Parameters:
- TICK_DIV, 100, clk cycles per count tick; legal range 2 or more.
- IDLE_CYCLES, 3000, clk cycles of inactivity in IDLE/PAUSED before entering SLEEP; legal range 2 or more.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_ss  in  1  start/stop button; debounced level, synchronous to clk.
- btn_lr  in  1  lap/reset button; debounced level, synchronous to clk.
- cnt_en  out  1  one-cycle increment pulse to the counter chain.
- cnt_clear  out  1  one-cycle synchronous clear pulse to the counter chain.
- pause  out  1  hold level to the datapath; 1 = hold.
- disp_hold  out  1  display latch; 1 = frozen lap value.
- disp_blank  out  1  display blank; 1 = power save.
- state  out  3  current FSM encoding: IDLE=0, RUN=1, LAP=2, PAUSED=3, SLEEP=4.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; prescaler=0; idle counter=0; edge registers=0.
  - cnt_en=0, cnt_clear=0, pause=1, disp_hold=0, disp_blank=0.
- Reset mid-operation aborts the current state immediately; no clear pulse is issued.
- Edge detect: one register per button.
  - ss_ev = btn_ss & ~btn_ss_q; lr_ev = btn_lr & ~btn_lr_q.
  - Events are single-cycle; a held button produces exactly one event.
- Event priority: if ss_ev and lr_ev occur in the same cycle, ss_ev is acted on and lr_ev is discarded.
- Prescaler:
  - Width clog2(TICK_DIV); counts only in RUN and LAP.
  - At value TICK_DIV-1 it wraps to 0, and cnt_en=1 in that same cycle (combinational from the registered count).
  - In PAUSED it holds its value, so the tick phase is preserved.
  - Cleared to 0 on the IDLE->RUN transition.
- FSM transitions (registered; outputs are Moore decodes of state except cnt_en and cnt_clear):
  - IDLE: pause=1. ss_ev -> RUN. lr_ev -> IDLE with a cnt_clear pulse.
  - RUN: pause=0. ss_ev -> PAUSED. lr_ev -> LAP.
  - LAP: pause=0, disp_hold=1; counting continues. lr_ev -> RUN (hold released). ss_ev -> PAUSED (hold released).
  - PAUSED: pause=1. ss_ev -> RUN. lr_ev -> IDLE, with cnt_clear=1 for exactly the cycle the IDLE state is entered.
  - SLEEP: pause=1, disp_blank=1. Any event -> return state (IDLE or PAUSED, stored in a 1-bit register on entry). The waking event is consumed: no other action, no clear.
- Latency: a button edge at cycle n produces an event at n+1 and the new state/outputs at n+2.
- Idle counter:
  - Counts clk cycles while in IDLE or PAUSED.
  - Zeroed on any event and in any other state.
  - Saturates at IDLE_CYCLES-1.
- The clear pulse and the tick pulse never coincide, because the prescaler is not counting in PAUSED or IDLE.

Optional Feature:
STOPWATCH_AUTOSLEEP_EN
- Defined:
  - Idle counter reaching IDLE_CYCLES-1 moves IDLE/PAUSED -> SLEEP on the next cycle.
  - A datapath power-saver flag input port, psave_req (in, 1), also forces SLEEP from IDLE or PAUSED on the cycle after it is seen high.
- Undefined:
  - Idle counter, psave_req port and SLEEP state logic are not compiled.
  - disp_blank is tied to 0.
  - state never reads 4.

Test Plan (TICK_DIV=4, IDLE_CYCLES=20):
- Reset low mid-RUN, then release -> state=0, pause=1, all pulses 0. The first ss_ev gives state=1 two cycles after the press; the first cnt_en follows 4 cycles later, then one every 4 cycles.
- RUN 10 cycles, ss_ev, hold 7 cycles, ss_ev -> no cnt_en while PAUSED. Prescaler phase resumes, so the next cnt_en arrives 2 cycles after resuming (phase 2 retained).
- RUN, lr_ev -> state=2 and disp_hold=1 while cnt_en continues every 4 cycles. Second lr_ev -> state=1, disp_hold=0.
- PAUSED, lr_ev -> exactly one cnt_clear cycle, state=0. Holding btn_lr high 10 cycles produces no second clear.
- Same-cycle rising edges of btn_ss and btn_lr in RUN -> state=3 (PAUSED), no LAP entry, no clear.
- With STOPWATCH_AUTOSLEEP_EN:
  - PAUSED idle 20 cycles -> state=4, disp_blank=1.
  - lr_ev -> state=3 with no clear.
  - From PAUSED, psave_req=1 -> state=4 on the next cycle.
